// File: rtl/regfile_pkg.sv
// regfile_pkg: default register file geometry and index/data word types shared by decode and writeback.
package regfile_pkg;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = $clog2(NREGS);
    localparam int NUM_RD = 2;
    localparam int SP_REG = 2;
    localparam logic [XLEN-1:0] SP_RESET = 32'h3FC;
    localparam int CNT_REG = 30;
    localparam int PEND_W = 2;
    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write counters, issue acceptance, underflow flag and read hazards.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = regfile_pkg::NREGS,
    parameter int AW = $clog2(NREGS),
    parameter int NUM_RD = regfile_pkg::NUM_RD,
    parameter int PEND_W = regfile_pkg::PEND_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_hazard,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic                 iss_ok,
    input  logic                 wb_en,
    input  logic [AW-1:0]        wb_addr,
    output logic                 wb_underflow
);
    logic [PEND_W-1:0] r_pend [NREGS];
    logic              r_underflow;
    logic              w_iss_go;
    logic [NREGS-1:0]  w_inc;
    logic [NREGS-1:0]  w_dec;

    assign iss_ok = !(iss_en && iss_addr != '0 && &r_pend[iss_addr]);
    assign w_iss_go = iss_en && iss_addr != '0 && iss_ok;
    assign wb_underflow = r_underflow;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_inc[r] = w_iss_go && iss_addr == AW'(r);
            w_dec[r] = wb_en && wb_addr == AW'(r) && r_pend[r] != '0;
        end
    end

    // r_pend[0] never moves: issues to r0 are gated out and it never leaves zero to decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) r_pend[r] <= '0;
            r_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_inc[r] && !w_dec[r]) r_pend[r] <= r_pend[r] + 1'b1;
                else if (w_dec[r] && !w_inc[r]) r_pend[r] <= r_pend[r] - 1'b1;
            end
            if (wb_en && wb_addr != '0 && r_pend[wb_addr] == '0) r_underflow <= 1'b1;
        end
    end

    // a writeback retiring the last outstanding write is covered by the bypass
    for (genvar i = 0; i < NUM_RD; i++) begin : g_hz
        logic [AW-1:0] w_a;
        assign w_a = rd_addr[i*AW +: AW];
        assign rd_hazard[i] = w_a != '0 && r_pend[w_a] != '0
                              && !(wb_en && wb_addr == w_a && r_pend[w_a] == PEND_W'(1));
    end
endmodule

// File: rtl/multiport_regfile.sv
// multiport_regfile: NUM_RD-read / one-write register file with bypass, zero reg, reset SP,
// free-running cycle counter register and a RAW-hazard scoreboard.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int NREGS = regfile_pkg::NREGS,
    parameter int AW = $clog2(NREGS),
    parameter int NUM_RD = regfile_pkg::NUM_RD,
    parameter int SP_REG = regfile_pkg::SP_REG,
    parameter logic [XLEN-1:0] SP_RESET = XLEN'(regfile_pkg::SP_RESET),
    parameter int CNT_REG = regfile_pkg::CNT_REG,
    parameter int PEND_W = regfile_pkg::PEND_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_hazard,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    output logic                   iss_ok,
    input  logic                   wb_en,
    input  logic [AW-1:0]          wb_addr,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   wb_underflow
);
    logic [XLEN-1:0] r_regs [NREGS];

    // r0 is never written so it holds its reset zero; a CNT_REG of 0 never matches r>=1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) r_regs[r] <= (r == SP_REG) ? SP_RESET : '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wb_en && wb_addr == AW'(r)) r_regs[r] <= wb_data;
                else if (r == CNT_REG) r_regs[r] <= r_regs[r] + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] w_a;
        assign w_a = rd_addr[i*AW +: AW];
        assign rd_data[i*XLEN +: XLEN] = w_a == '0 ? '0 : (wb_en && wb_addr == w_a) ? wb_data : r_regs[w_a];
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .NUM_RD(NUM_RD),
        .PEND_W(PEND_W)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_hazard   (rd_hazard),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .iss_ok      (iss_ok),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_underflow(wb_underflow)
    );
endmodule

// File: tb/tb_multiport_regfile.sv
// tb_multiport_regfile: directed vectors with hand-computed expectations for multiport_regfile.
module tb_multiport_regfile;
    import regfile_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    reg_idx_t         ra0, ra1;
    logic [2*XLEN-1:0] rd_data;
    logic [1:0]       rd_hazard;
    logic             iss_en, iss_ok, wb_en, wb_underflow;
    reg_idx_t         iss_addr, wb_addr;
    word_t            wb_data;
    int               n_chk = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    multiport_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     ({ra1, ra0}),
        .rd_data     (rd_data),
        .rd_hazard   (rd_hazard),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .iss_ok      (iss_ok),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_underflow(wb_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ra0 = '0; ra1 = '0;
        iss_en = 1'b0; iss_addr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ra0 = 5'd0; ra1 = 5'd2; settle();
        check("rst_r0", rd_data[31:0], 32'h0);
        check("rst_sp", rd_data[63:32], 32'h3FC);
        check("rst_hz", 32'(rd_hazard), 32'h0);
        check("rst_uf", 32'(wb_underflow), 32'h0);
        ra1 = 5'd30; settle();
        check("rst_cnt", rd_data[63:32], 32'h0);
        repeat (10) tick();
        ra0 = 5'd30; settle();
        check("cnt10", rd_data[31:0], 32'd10);
        iss_en = 1'b1; iss_addr = 5'd30; tick();
        iss_en = 1'b0; settle();
        check("cnt_hz", 32'(rd_hazard[0]), 32'h1);
        wb_en = 1'b1; wb_addr = 5'd30; wb_data = 32'h100; settle();
        check("cnt_byp", rd_data[31:0], 32'h100);
        check("cnt_hzbyp", 32'(rd_hazard[0]), 32'h0);
        tick();
        wb_en = 1'b0; settle();
        check("cnt_ld", rd_data[31:0], 32'h100);
        tick();
        check("cnt_inc", rd_data[31:0], 32'h101);
        iss_en = 1'b1; iss_addr = 5'd5; tick();
        iss_en = 1'b0;
        ra0 = 5'd5; ra1 = 5'd5;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF; settle();
        check("byp_p0", rd_data[31:0], 32'hDEAD_BEEF);
        check("byp_p1", rd_data[63:32], 32'hDEAD_BEEF);
        tick();
        wb_en = 1'b0; settle();
        check("wr_p0", rd_data[31:0], 32'hDEAD_BEEF);
        check("wr_uf", 32'(wb_underflow), 32'h0);
        ra1 = 5'd7;
        for (int k = 0; k < 3; k++) begin
            iss_en = 1'b1; iss_addr = 5'd7; settle();
            check("iss_ok", 32'(iss_ok), 32'h1);
            tick();
        end
        iss_en = 1'b0; settle();
        check("hz7", 32'(rd_hazard), 32'b10);
        iss_en = 1'b1; settle();
        check("iss_full", 32'(iss_ok), 32'h0);
        tick();
        iss_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h70 + 32'(k); settle();
            check("wb_hz", 32'(rd_hazard[1]), k == 2 ? 32'h0 : 32'h1);
            tick();
        end
        wb_en = 1'b0; settle();
        check("hz7_clr", 32'(rd_hazard[1]), 32'h0);
        check("r7", rd_data[63:32], 32'h72);
        check("sat_uf", 32'(wb_underflow), 32'h0);
        iss_en = 1'b1; iss_addr = 5'd7; tick();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77; settle();
        check("same_ok", 32'(iss_ok), 32'h1);
        tick();
        iss_en = 1'b0; wb_en = 1'b0; settle();
        check("same_hz", 32'(rd_hazard[1]), 32'h1);
        wb_en = 1'b1; wb_data = 32'h78; tick();
        wb_en = 1'b0; settle();
        check("same_clr", 32'(rd_hazard[1]), 32'h0);
        check("same_uf", 32'(wb_underflow), 32'h0);
        ra0 = 5'd9; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234_5678; tick();
        wb_en = 1'b0; settle();
        check("uf_data", rd_data[31:0], 32'h1234_5678);
        check("uf_set", 32'(wb_underflow), 32'h1);
        repeat (2) tick();
        check("uf_hold", 32'(wb_underflow), 32'h1);
        ra1 = 5'd11; iss_en = 1'b1; iss_addr = 5'd11; tick();
        iss_en = 1'b0; settle();
        check("hz11", 32'(rd_hazard[1]), 32'h1);
        #2 rst_n = 1'b0; settle();
        check("arst_uf", 32'(wb_underflow), 32'h0);
        check("arst_hz", 32'(rd_hazard), 32'h0);
        check("arst_r9", rd_data[31:0], 32'h0);
        ra1 = 5'd2; settle();
        check("arst_sp", rd_data[63:32], 32'h3FC);
        tick();
        rst_n = 1'b1;
        ra0 = 5'd0; ra1 = 5'd0;
        iss_en = 1'b1; iss_addr = 5'd0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; settle();
        check("z_ok", 32'(iss_ok), 32'h1);
        check("z_rd", rd_data[31:0], 32'h0);
        check("z_hz", 32'(rd_hazard), 32'h0);
        tick();
        iss_en = 1'b0; wb_en = 1'b0; settle();
        check("z_rd2", rd_data[63:32], 32'h0);
        check("z_hz2", 32'(rd_hazard), 32'h0);
        check("z_uf", 32'(wb_underflow), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/multiport_regfile.md
Name: multiport_regfile

Overview:
- Parametrised successor to the single-issue register file in the decode stage.
- Provides NUM_RD combinational read ports, one writeback port, and same-cycle write-to-read bypass.
- Keeps a hard-wired zero register, a reset-initialised stack pointer and a free-running cycle counter register.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards and stall itself, without external forwarding glue.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; must be a power of 2, minimum 4.
- AW, $clog2(NREGS), register index width.
- NUM_RD, 2, number of read ports.
- SP_REG, 2, index of the stack pointer register.
- SP_RESET, 32'h3FC, reset value of the stack pointer register.
- CNT_REG, 30, index of the cycle counter register; 0 disables the counter.
- PEND_W, 2, width of each pending counter; maximum in-flight writes per register is 2^PEND_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*AW  read indices; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rd_hazard  out  NUM_RD  port i has an unresolved pending write to its register.
- iss_en  in  1  decode issues an instruction that will write iss_addr.
- iss_addr  in  AW  destination register of the issued instruction.
- iss_ok  out  1  issue accepted this cycle (combinational).
- wb_en  in  1  writeback valid.
- wb_addr  in  AW  writeback destination register.
- wb_data  in  XLEN  writeback data.
- wb_underflow  out  1  sticky error flag: a writeback arrived with no pending issue.

Behaviour:
- Reset (asynchronous, active-low):
  - All registers clear to 0, except SP_REG, which loads SP_RESET.
  - All pending counters clear to 0; wb_underflow clears to 0.
  - rd_data reflects the reset contents immediately; rd_hazard is all 0.
- Register 0:
  - Always reads 0.
  - Writes to it are dropped.
  - Issues to it are accepted (iss_ok=1) but never counted.
- Write:
  - On the rising edge when wb_en=1 and wb_addr!=0, regs[wb_addr] <= wb_data.
- Read (combinational, zero latency):
  - rd_data[i] = 0 if rd_addr[i]==0.
  - Otherwise, if wb_en=1 and wb_addr==rd_addr[i], rd_data[i] = wb_data (bypass).
  - Otherwise, rd_data[i] = regs[rd_addr[i]].
- Counter register (only when CNT_REG!=0):
  - Increments by 1 every clock edge, modulo 2^XLEN.
  - A writeback to CNT_REG on the same edge wins: it loads wb_data and the increment is skipped.
  - A read returns the pre-increment value, or the bypassed wb_data during a writeback.
- Scoreboard, per register r (1..NREGS-1), counter pend[r]:
  - Issue attempt occurs when iss_en=1 and iss_addr!=0.
  - iss_ok = !(iss_en && iss_addr!=0 && pend[iss_addr]==all-ones).
  - A rejected issue leaves state unchanged; decode must hold and retry.
  - Increment when an accepted issue targets r.
  - Decrement when wb_en=1 and wb_addr==r and pend[r]!=0.
  - Issue and writeback to the same r on the same edge leave pend[r] unchanged.
  - Writeback with pend[r]==0: data is still written, pend[r] stays 0, wb_underflow sets and holds until reset.
- Hazard:
  - rd_hazard[i] = rd_addr[i]!=0 && pend[rd_addr[i]]!=0 && !(wb_en && wb_addr==rd_addr[i] && pend[rd_addr[i]]==1).
  - The bypass covers the last outstanding write.
- Reset mid-operation: all pending state is lost; in-flight writebacks after reset raise wb_underflow. This is intended and marks a pipeline-flush bug.
- Multiple read ports may name the same register; each port resolves independently.

Decomposition:
- Shared package regfile_pkg holds:
  - default XLEN, NREGS, SP_REG, SP_RESET, CNT_REG and PEND_W localparams;
  - a typedef for register index and data words, shared with decode and writeback stages.
- Sub-module rf_scoreboard: one instance holding the pend array, iss_ok, wb_underflow and the per-port hazard logic. Data storage, bypass and counter stay in the top level.

Test Plan:
- Reset: release rst_n; read ports at 0 and 2 -> rd_data 0 and 32'h3FC; rd_hazard 00; wb_underflow 0.
- Write and bypass: wb_en=1, wb_addr=5, wb_data=32'hDEAD_BEEF with rd_addr[0]=5 in the same cycle -> rd_data[0]=DEADBEEF before the edge; still DEADBEEF after the edge with wb_en=0.
- Counter: idle 10 cycles after reset -> regs[30] reads 10. Then wb to 30 with 32'h100 -> next cycle reads 32'h100, following cycle 32'h101.
- Scoreboard saturation:
  - Issue r7 three times -> iss_ok 1,1,1; hazard on port reading 7.
  - Fourth issue -> iss_ok=0.
  - Three writebacks -> hazard clears during the third writeback cycle.
  - Issue and wb to r7 on the same edge -> count unchanged.
- Underflow: wb to r9 with nothing pending -> data written; wb_underflow=1 and stays 1. Assert rst_n low mid-cycle -> flag and all pend clear asynchronously.
- Zero register: iss r0 and wb r0 with data 32'hFFFF_FFFF -> iss_ok=1, no hazard, r0 still reads 0.
